apu_length_counter_bank: RTL and testbench
==========================================

APU_LENGTH_COUNTER_BANK -- requirements
Module: apu_length_counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of length-counter channels (1..8).
REQ-002 SHALL have parameter CW, default 8, counter width in bits (>= 8).
REQ-003 SHALL have parameter IMMEDIATE, default 0: 0 = CPU load deferred to next half-frame tick; 1 = load applied on the write cycle.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hframe, input, 1, half-frame tick, one clk cycle wide.
REQ-007 SHALL have port en, input, NCH, per-channel enable (status-register enable bits).
REQ-008 SHALL have port halt, input, NCH, per-channel halt (no decrement).
REQ-009 SHALL have port load_we, input, 1, CPU length-load write strobe, one cycle.
REQ-010 SHALL have port load_ch, input, $clog2(NCH) (min 1), target channel of the write.
REQ-011 SHALL have port load_idx, input, 5, length-table index.
REQ-012 SHALL have port act, output, NCH, combinational count != 0 per channel.
REQ-013 SHALL have port gate, output, NCH, registered count != 0, sampled on hframe.

Function
REQ-014 Each channel SHALL hold cnt[CW], pend (1 bit), pidx[5].
REQ-015 Length value SHALL be LEN_TABLE[idx] zero-extended to CW; table: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-016 Writes with load_ch >= NCH, or to a channel with en=0, SHALL be ignored.
REQ-017 IMMEDIATE=0: accepted write SHALL set pend=1 and pidx=load_idx; a later write before hframe overwrites pidx.
REQ-018 IMMEDIATE=0: on hframe, pend=1 channel SHALL load cnt=LEN_TABLE[pidx] and clear pend; no decrement that tick.
REQ-019 IMMEDIATE=0: write coinciding with hframe on the same channel SHALL load LEN_TABLE[load_idx] on that tick; pend stays 0.
REQ-020 IMMEDIATE=1: accepted write SHALL load cnt next cycle; if coincident with hframe, load wins and decrement is skipped.
REQ-021 On hframe with no load, channel with halt=0 and cnt!=0 SHALL decrement by 1; cnt=0 SHALL stay 0 (no wrap).
REQ-022 halt=1 SHALL freeze cnt; halt SHALL not block loads.
REQ-023 On hframe, gate[i] SHALL take (cnt[i] != 0) evaluated before that tick's load/decrement; gate holds between ticks.
REQ-024 en[i]=0 SHALL, next cycle and every cycle it stays low, force cnt=0, pend=0, gate=0, overriding hframe and writes.
REQ-025 Channels SHALL be fully independent; simultaneous hframe on all channels SHALL be handled in one cycle.

Reset
REQ-026 reset=1 SHALL set all cnt=0, pend=0, pidx=0, gate=0 at the next clk edge; act=0 follows combinationally.
REQ-027 reset SHALL override hframe, load_we and en; a pending load is discarded by reset mid-operation.

Structure
REQ-028 LEN_TABLE (32 x 8-bit constant) and LEN_IDX_W=5 SHALL live in shared package apu_pkg.
REQ-029 Per-channel logic SHALL be sub-module apu_length_channel, instantiated NCH times via generate; top decodes load_ch.
REQ-030 Table lookup SHALL be a combinational constant index, no clocked ROM, so load latency is fixed.

Verification
REQ-031 IMMEDIATE=0, en[0]=1, write ch0 idx 3, then hframe -> cnt0=2, act[0]=1; next hframe -> cnt0=1, gate[0]=1; next -> cnt0=0; next -> gate[0]=0, act[0]=0.
REQ-032 IMMEDIATE=0, ch1 write idx 0 then idx 1 before hframe -> hframe loads 254, not 10.
REQ-033 ch2 loaded 10, halt[2]=1, 5 hframes -> cnt2=10; halt=0, 1 hframe -> 9; write with load_ch=NCH -> no channel changes.
REQ-034 IMMEDIATE=1, write ch0 idx 1 same cycle as hframe -> cnt0=254 next cycle, no decrement.
REQ-035 cnt3=40, drop en[3] mid-count -> cnt3=0, gate[3]=0 next cycle; writes to ch3 ignored while en[3]=0.
REQ-036 Pending write on ch0, reset pulse before hframe -> after hframe cnt0=0, act=0, gate=0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter table and its index width.
package apu_pkg;

    localparam int unsigned LEN_IDX_W = 5;
    localparam int unsigned LEN_DEPTH = 32;

    localparam logic [7:0] LEN_TABLE [LEN_DEPTH] = '{
        8'd10,  8'd254, 8'd20,  8'd2,  8'd40,  8'd4,  8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10, 8'd14,  8'd12, 8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18, 8'd48,  8'd20, 8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26, 8'd16,  8'd28, 8'd32,  8'd30
    };

    // Purely combinational lookup so load latency never depends on the index.
    function automatic logic [7:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_length_counter_bank_if.sv
// Decoded per-channel length-load write bus (strobe + table index).
interface apu_length_counter_bank_if;
    import apu_pkg::*;

    logic                 we;
    logic [LEN_IDX_W-1:0] idx;

    modport master (output we, idx);
    modport slave  (input  we, idx);

endinterface

// File: rtl/apu_length_channel.sv
// One length counter: count, deferred-load slot and half-frame gate sample.
module apu_length_channel
    import apu_pkg::*;
#(
    parameter int unsigned CW        = 8,
    parameter int unsigned IMMEDIATE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hframe,
    input  logic                      en,
    input  logic                      halt,
    apu_length_counter_bank_if.slave  wr,
    output logic                      act,
    output logic                      gate
);

    logic [CW-1:0]        cnt_q,  cnt_d;
    logic                 pend_q, pend_d;
    logic [LEN_IDX_W-1:0] pidx_q, pidx_d;
    logic                 gate_q, gate_d;

    logic [CW-1:0]        load_val;
    logic [CW-1:0]        pend_val;

    assign load_val = CW'(len_lookup(wr.idx));
    assign pend_val = CW'(len_lookup(pidx_q));

    // Disable wins over everything; a load on a tick replaces that tick's decrement.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        pidx_d = pidx_q;
        gate_d = gate_q;
        if (!en) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            gate_d = 1'b0;
        end else begin
            if (hframe) begin
                gate_d = (cnt_q != '0);
            end
            if (IMMEDIATE != 0) begin
                if (wr.we) begin
                    cnt_d = load_val;
                end else if (hframe && !halt && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (hframe) begin
                if (wr.we) begin
                    cnt_d  = load_val;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    cnt_d  = pend_val;
                    pend_d = 1'b0;
                end else if (!halt && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (wr.we) begin
                pend_d = 1'b1;
                pidx_d = wr.idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            pidx_q <= '0;
            gate_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            pidx_q <= pidx_d;
            gate_q <= gate_d;
        end
    end

    assign act  = (cnt_q != '0);
    assign gate = gate_q;

endmodule

// File: rtl/apu_length_counter_bank.sv
// Bank of NCH independent length counters sharing one CPU load port.
module apu_length_counter_bank
    import apu_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CW        = 8,
    parameter int unsigned IMMEDIATE = 0,
    localparam int unsigned LCW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hframe,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       halt,
    input  logic                 load_we,
    input  logic [LCW-1:0]       load_ch,
    input  logic [LEN_IDX_W-1:0] load_idx,
    output logic [NCH-1:0]       act,
    output logic [NCH-1:0]       gate
);

    logic ch_ok;

    // Out-of-range channel numbers are possible when NCH is not a power of two.
    assign ch_ok = (32'(load_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        apu_length_counter_bank_if wr_if ();

        assign wr_if.we  = load_we && ch_ok && (load_ch == LCW'(i)) && en[i];
        assign wr_if.idx = load_idx;

        apu_length_channel #(
            .CW        (CW),
            .IMMEDIATE (IMMEDIATE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .hframe (hframe),
            .en     (en[i]),
            .halt   (halt[i]),
            .wr     (wr_if.slave),
            .act    (act[i]),
            .gate   (gate[i])
        );
    end

endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Bench for apu_length_counter_bank: deferred and immediate variants run side by side.
module tb_apu_length_counter_bank;
    import apu_pkg::*;

    localparam int unsigned N = 5;

    logic         clk;
    logic         reset;
    logic         hframe;
    logic [N-1:0] en;
    logic [N-1:0] halt;
    logic [2:0]   load_ch;
    logic [N-1:0] act0, gate0, act1, gate1;

    apu_length_counter_bank_if ld ();

    apu_length_counter_bank #(.NCH(N), .CW(8), .IMMEDIATE(0)) dut0 (
        .clk(clk), .reset(reset), .hframe(hframe), .en(en), .halt(halt),
        .load_we(ld.we), .load_ch(load_ch), .load_idx(ld.idx),
        .act(act0), .gate(gate0));

    apu_length_counter_bank #(.NCH(N), .CW(8), .IMMEDIATE(1)) dut1 (
        .clk(clk), .reset(reset), .hframe(hframe), .en(en), .halt(halt),
        .load_we(ld.we), .load_ch(load_ch), .load_idx(ld.idx),
        .act(act1), .gate(gate1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per design variant (0 = deferred, 1 = immediate).
    int mcnt  [2][N];
    bit mpend [2][N];
    int mpidx [2][N];
    bit mgate [2][N];

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic chk_vec(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic model_step(input int d);
        for (int i = 0; i < N; i++) begin
            bit acc;
            int len;
            acc = ld.we && (int'(load_ch) == i);
            len = int'(LEN_TABLE[ld.idx]);
            if (reset) begin
                mcnt[d][i] = 0; mpend[d][i] = 0; mpidx[d][i] = 0; mgate[d][i] = 0;
            end else if (!en[i]) begin
                mcnt[d][i] = 0; mpend[d][i] = 0; mgate[d][i] = 0;
            end else begin
                if (hframe) mgate[d][i] = (mcnt[d][i] != 0);
                if (d == 1) begin
                    if (acc) mcnt[d][i] = len;
                    else if (hframe && !halt[i] && mcnt[d][i] > 0) mcnt[d][i]--;
                end else if (hframe) begin
                    if (acc) begin
                        mcnt[d][i] = len; mpend[d][i] = 0;
                    end else if (mpend[d][i]) begin
                        mcnt[d][i] = int'(LEN_TABLE[mpidx[d][i]]); mpend[d][i] = 0;
                    end else if (!halt[i] && mcnt[d][i] > 0) begin
                        mcnt[d][i]--;
                    end
                end else if (acc) begin
                    mpend[d][i] = 1; mpidx[d][i] = int'(ld.idx);
                end
            end
        end
    endtask

    function automatic logic [N-1:0] m_act(input int d);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (mcnt[d][i] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] m_gate(input int d);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mgate[d][i];
        return v;
    endfunction

    // One clock: advance the model with the applied inputs, then compare both variants.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk_vec("act0_model",  act0,  m_act(0));
        chk_vec("gate0_model", gate0, m_gate(0));
        chk_vec("act1_model",  act1,  m_act(1));
        chk_vec("gate1_model", gate1, m_gate(1));
    endtask

    task automatic check_cnt(input string name, input int d, input int ch, input int expected);
        int v;
        case (d * 8 + ch)
            0:  v = int'(dut0.gen_ch[0].u_ch.cnt_q);
            1:  v = int'(dut0.gen_ch[1].u_ch.cnt_q);
            2:  v = int'(dut0.gen_ch[2].u_ch.cnt_q);
            3:  v = int'(dut0.gen_ch[3].u_ch.cnt_q);
            4:  v = int'(dut0.gen_ch[4].u_ch.cnt_q);
            8:  v = int'(dut1.gen_ch[0].u_ch.cnt_q);
            9:  v = int'(dut1.gen_ch[1].u_ch.cnt_q);
            10: v = int'(dut1.gen_ch[2].u_ch.cnt_q);
            11: v = int'(dut1.gen_ch[3].u_ch.cnt_q);
            default: v = int'(dut1.gen_ch[4].u_ch.cnt_q);
        endcase
        chk(name, v, expected);
    endtask

    task automatic idle();
        reset = 1'b0; hframe = 1'b0; ld.we = 1'b0; load_ch = 3'd0; ld.idx = 5'd0;
    endtask

    task automatic write(input int ch, input int idx, input bit hf);
        idle();
        ld.we = 1'b1; load_ch = 3'(ch); ld.idx = 5'(idx); hframe = hf;
        cycle();
        idle();
    endtask

    task automatic tick();
        idle();
        hframe = 1'b1;
        cycle();
        idle();
    endtask

    typedef struct {
        logic       rst;
        logic       hf;
        logic       we;
        logic [2:0] ch;
        logic [4:0] idx;
        int         e_cnt;
        logic       e_act;
        logic       e_gate;
    } vec_t;

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{rst:1, hf:0, we:0, ch:0, idx:0, e_cnt:0, e_act:0, e_gate:0};
        vt[1] = '{rst:0, hf:0, we:1, ch:0, idx:3, e_cnt:0, e_act:0, e_gate:0};
        vt[2] = '{rst:0, hf:1, we:0, ch:0, idx:0, e_cnt:2, e_act:1, e_gate:0};
        vt[3] = '{rst:0, hf:0, we:0, ch:0, idx:0, e_cnt:2, e_act:1, e_gate:0};
        vt[4] = '{rst:0, hf:1, we:0, ch:0, idx:0, e_cnt:1, e_act:1, e_gate:1};
        vt[5] = '{rst:0, hf:1, we:0, ch:0, idx:0, e_cnt:0, e_act:0, e_gate:1};
        vt[6] = '{rst:0, hf:1, we:0, ch:0, idx:0, e_cnt:0, e_act:0, e_gate:0};

        idle();
        en = '1; halt = '0;
        @(negedge clk);

        // Deferred load of index 3 then count down to zero on ch0.
        for (int i = 0; i < 7; i++) begin
            reset = vt[i].rst; hframe = vt[i].hf; ld.we = vt[i].we;
            load_ch = vt[i].ch; ld.idx = vt[i].idx;
            cycle();
            check_cnt("tbl_cnt0", 0, 0, vt[i].e_cnt);
            chk("tbl_act0",  int'(act0[0]),  int'(vt[i].e_act));
            chk("tbl_gate0", int'(gate0[0]), int'(vt[i].e_gate));
        end
        idle();

        // Second write before the tick replaces the pending index.
        write(1, 0, 0);
        write(1, 1, 0);
        tick();
        check_cnt("overwrite_cnt1", 0, 1, 254);

        // Halt freezes the count; an out-of-range channel write touches nothing.
        write(2, 0, 0);
        tick();
        check_cnt("load_cnt2", 0, 2, 10);
        halt[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            cycle();
        end
        check_cnt("halt_cnt2", 0, 2, 10);
        halt[2] = 1'b0;
        tick();
        check_cnt("unhalt_cnt2", 0, 2, 9);
        write(N, 1, 0);
        tick();
        check_cnt("oor_cnt2", 0, 2, 8);
        for (int c = 0; c < N; c++) check_cnt("oor_model", 0, c, mcnt[0][c]);

        // Immediate variant: load coincident with tick wins, no decrement.
        write(0, 1, 1);
        check_cnt("imm_cnt0", 1, 0, 254);
        cycle();
        check_cnt("imm_hold_cnt0", 1, 0, 254);

        // Dropping enable clears mid-count and blocks writes.
        write(3, 4, 0);
        tick();
        check_cnt("en_load_cnt3", 0, 3, 40);
        tick();
        check_cnt("en_dec_cnt3", 0, 3, 39);
        chk("en_gate3_before", int'(gate0[3]), 1);
        en[3] = 1'b0;
        cycle();
        check_cnt("en_off_cnt3", 0, 3, 0);
        chk("en_off_gate3", int'(gate0[3]), 0);
        write(3, 1, 0);
        tick();
        check_cnt("en_off_wr_cnt3", 0, 3, 0);
        chk("en_off_act3", int'(act0[3]), 0);
        en[3] = 1'b1;
        cycle();

        // Reset discards a pending load.
        write(0, 5, 0);
        reset = 1'b1;
        cycle();
        idle();
        tick();
        check_cnt("rst_pend_cnt0", 0, 0, 0);
        chk_vec("rst_pend_act",  act0,  '0);
        chk_vec("rst_pend_gate", gate0, '0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 199) == 0);
            hframe  = ($urandom_range(0, 3) == 0);
            ld.we   = ($urandom_range(0, 1) == 1);
            load_ch = 3'($urandom_range(0, 7));
            ld.idx  = 5'($urandom_range(0, 31));
            for (int b = 0; b < N; b++) begin
                en[b]   = ($urandom_range(0, 19) != 0);
                halt[b] = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
